// File: rtl/fixed_accumulator_pkg.sv
// fixed_accumulator_pkg: shared sign-magnitude widths, FSM states and -0 normalisation
package fixed_accumulator_pkg;
    localparam int SM_W = 18;
    localparam logic [SM_W-2:0] SM_MAG_MAX = 17'h1FFFF;
    typedef enum logic {ACCUM, HOLD} state_t;
    function automatic logic [SM_W-1:0] sm_norm(input logic [SM_W-1:0] x);
        return (x[SM_W-2:0] == '0) ? '0 : x;
    endfunction
endpackage

// File: rtl/fixed_accumulator_if.sv
// fixed_accumulator_if: product stream in, window result out, both valid/ready
interface fixed_accumulator_if;
    import fixed_accumulator_pkg::*;
    logic            in_valid;
    logic            in_ready;
    logic [SM_W-1:0] in_data;
    logic [SM_W-1:0] bias;
    logic            out_valid;
    logic            out_ready;
    logic [SM_W-1:0] out_data;
    logic            out_ovf;
    modport slave (input in_valid, in_data, bias, out_ready, output in_ready, out_valid, out_data, out_ovf);
    modport master (output in_valid, in_data, bias, out_ready, input in_ready, out_valid, out_data, out_ovf);
endinterface

// File: rtl/fixed_sat_adder.sv
// fixed_sat_adder: combinational saturating sign-magnitude add, cancellation yields +0
module fixed_sat_adder
    import fixed_accumulator_pkg::*;
(
    input  logic [SM_W-1:0] a,
    input  logic [SM_W-1:0] b,
    output logic [SM_W-1:0] sum,
    output logic            ovf
);
    logic [SM_W-1:0] raw;
    logic [SM_W-2:0] ma, mb, mag;
    logic            same, a_ge, sign;
    always_comb begin
        ma   = a[SM_W-2:0];
        mb   = b[SM_W-2:0];
        raw  = {1'b0, ma} + {1'b0, mb};
        same = a[SM_W-1] == b[SM_W-1];
        a_ge = ma >= mb;
        ovf  = same & raw[SM_W-1];
        mag  = same ? (ovf ? SM_MAG_MAX : raw[SM_W-2:0]) : (a_ge ? ma - mb : mb - ma);
        sign = same ? a[SM_W-1] : (a_ge ? a[SM_W-1] : b[SM_W-1]);
        sum  = sm_norm({sign, mag});
    end
endmodule

// File: rtl/fixed_accumulator.sv
// fixed_accumulator: sums NUM_TERMS sign-magnitude products onto a bias per window,
// emitting one saturated, optionally ReLU-clipped result per window.
module fixed_accumulator
    import fixed_accumulator_pkg::*;
#(
    parameter int NUM_TERMS = 25,
    parameter bit RELU_EN   = 1'b1
) (
    input logic                clk,
    input logic                rst,
    fixed_accumulator_if.slave io
);
    localparam int CW = $clog2(NUM_TERMS + 1);
    state_t          state;
    logic [CW-1:0]   cnt;
    logic [SM_W-1:0] acc, op_a, sum, res;
    logic            ovf, add_ovf, ovf_nxt, last;
    fixed_sat_adder u_add (.a(op_a), .b(io.in_data), .sum(sum), .ovf(add_ovf));
    // The first term of a window restarts from bias, dropping the previous window's sum and sticky flag
    always_comb begin
        op_a    = (cnt == '0) ? io.bias : acc;
        ovf_nxt = ((cnt != '0) && ovf) || add_ovf;
        last    = cnt == CW'(NUM_TERMS - 1);
        res     = (RELU_EN && sum[SM_W-1]) ? '0 : sum;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ACCUM;
            cnt          <= '0;
            acc          <= '0;
            ovf          <= 1'b0;
            io.in_ready  <= 1'b1;
            io.out_valid <= 1'b0;
            io.out_data  <= '0;
            io.out_ovf   <= 1'b0;
        end else if (state == ACCUM && io.in_valid) begin
            acc <= sum;
            ovf <= ovf_nxt;
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) begin
                state        <= HOLD;
                io.in_ready  <= 1'b0;
                io.out_valid <= 1'b1;
                io.out_data  <= res;
                io.out_ovf   <= ovf_nxt;
            end
        end else if (state == HOLD && io.out_ready) begin
            state        <= ACCUM;
            io.in_ready  <= 1'b1;
            io.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fixed_accumulator.sv
// tb_fixed_accumulator: directed windows into a pass-through and a ReLU instance in lockstep,
// results checked by a scoreboard monitor against hand-computed values.
module tb_fixed_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [17:0] in_data = '0;
    logic [17:0] bias = '0;
    logic        out_ready = 1'b1;
    int          checks = 0;
    int          errors = 0;
    logic [18:0] q0[$];
    logic [18:0] q1[$];

    always #5 clk = ~clk;

    fixed_accumulator_if i0();
    fixed_accumulator_if i1();
    assign i0.in_valid = in_valid;
    assign i0.in_data = in_data;
    assign i0.bias = bias;
    assign i0.out_ready = out_ready;
    assign i1.in_valid = in_valid;
    assign i1.in_data = in_data;
    assign i1.bias = bias;
    assign i1.out_ready = out_ready;

    fixed_accumulator #(.NUM_TERMS(25), .RELU_EN(1'b0)) d0 (.clk(clk), .rst(rst), .io(i0.slave));
    fixed_accumulator #(.NUM_TERMS(25), .RELU_EN(1'b1)) d1 (.clk(clk), .rst(rst), .io(i1.slave));

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expected {ovf,data} per result handshake
    always @(negedge clk) begin
        if (!rst && i0.out_valid && out_ready) begin
            if (q0.size() == 0) chk("res0_unexpected", {1'b0, i0.out_ovf, i0.out_data}, 20'hFFFFF);
            else chk("res0", {1'b0, i0.out_ovf, i0.out_data}, {1'b0, q0.pop_front()});
        end
        if (!rst && i1.out_valid && out_ready) begin
            if (q1.size() == 0) chk("res1_unexpected", {1'b0, i1.out_ovf, i1.out_data}, 20'hFFFFF);
            else chk("res1", {1'b0, i1.out_ovf, i1.out_data}, {1'b0, q1.pop_front()});
        end
    end

    task automatic term(input logic [17:0] d, input logic [17:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data = d;
        bias = b;
        @(negedge clk);
        while (!i0.in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) chk("accept_timeout", 20'd0, 20'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // na terms of a, then 25-na terms of c; e0/e1 are the pass-through and ReLU results
    task automatic window(input logic [17:0] b, input logic [17:0] a, input int na, input logic [17:0] c,
                          input logic [17:0] e0, input logic [17:0] e1, input logic eo);
        q0.push_back({eo, e0});
        q1.push_back({eo, e1});
        for (int i = 0; i < 25; i++) term(i < na ? a : c, b);
        @(negedge clk);
        chk("latency0", {18'd0, i0.out_valid, i0.in_ready}, 20'b10);
        chk("latency1", {18'd0, i1.out_valid, i1.in_ready}, 20'b10);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset0", {i0.out_valid, i0.in_ready, i0.out_ovf, i0.out_data[16:0]}, 20'h40000);
        chk("reset1", {i1.out_valid, i1.in_ready, i1.out_ovf, i1.out_data[16:0]}, 20'h40000);
        chk("reset_sign", {18'd0, i0.out_data[17], i1.out_data[17]}, 20'd0);
        @(posedge clk);
        #1;
        window(18'h00010, 18'h00001, 25, 18'h00000, 18'h00029, 18'h00029, 1'b0);
        window(18'h20005, 18'h00000, 24, 18'h00005, 18'h00000, 18'h00000, 1'b0);
        window(18'h00000, 18'h20001, 3, 18'h20000, 18'h20003, 18'h00000, 1'b0);
        window(18'h20064, 18'h00002, 25, 18'h00000, 18'h20032, 18'h00000, 1'b0);
        window(18'h1FFFF, 18'h00001, 1, 18'h20001, 18'h1FFE7, 18'h1FFE7, 1'b1);
        window(18'h00000, 18'h00000, 25, 18'h00000, 18'h00000, 18'h00000, 1'b0);
        @(posedge clk);
        #1 out_ready = 1'b0;
        window(18'h00010, 18'h00001, 25, 18'h00000, 18'h00029, 18'h00029, 1'b0);
        #1;
        in_valid = 1'b1;
        in_data = 18'h00100;
        bias = 18'h00100;
        repeat (10) begin
            @(negedge clk);
            chk("hold0", {i0.out_valid, i0.in_ready, i0.out_data}, {2'b10, 18'h00029});
            chk("hold1", {i1.out_valid, i1.in_ready, i1.out_data}, {2'b10, 18'h00029});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        window(18'h00003, 18'h00001, 25, 18'h00000, 18'h0001C, 18'h0001C, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) term(18'h00100, 18'h00100);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midreset0", {18'd0, i0.out_valid, i0.in_ready}, 20'b01);
        chk("midreset1", {18'd0, i1.out_valid, i1.in_ready}, 20'b01);
        @(posedge clk);
        #1;
        window(18'h00010, 18'h00001, 25, 18'h00000, 18'h00029, 18'h00029, 1'b0);
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("drain", {10'd0, 5'(q0.size()), 5'(q1.size())}, 20'd0);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fixed_accumulator.md
Name: fixed_accumulator

Overview:
Sequential accumulator that sits directly downstream of the 18-bit sign-magnitude multiplier/adder path in the convolution engine. It consumes a stream of NUM_TERMS sign-magnitude products for one kernel window and adds them to a per-window bias. It emits one saturated, optionally ReLU-clipped 18-bit sign-magnitude result per window over a valid/ready handshake. That result feeds the pooling stage.

Parameters:
NUM_TERMS, 25, products per window (5x5 kernel); legal range 1..1023
RELU_EN, 1, 1 = clip negative results to +0 at output; 0 = pass signed result

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  product word valid
in_ready  output  1  accumulator can accept a product this cycle
in_data  input  18  product, sign-magnitude: [17] sign (1 = negative), [16:0] magnitude
bias  input  18  window bias, sign-magnitude; sampled only on the first accepted term of a window
out_valid  output  1  window result valid
out_ready  input  1  downstream accepts result
out_data  output  18  window result, sign-magnitude
out_ovf  output  1  1 = saturation occurred at some point in this window; qualified by out_valid

Behaviour:
- Number format: sign-magnitude throughout. -0 (0x20000) is legal on inputs and is treated as 0. out_data never carries 0x20000; it is normalised to 0x00000.
- Arithmetic: a combinational saturating sign-magnitude add.
  - Same signs: magnitude sum is computed at 18 bits. If the sum exceeds 0x1FFFF, magnitude = 0x1FFFF, sign is kept, and the sticky overflow bit is set.
  - Different signs: the larger magnitude minus the smaller, with the sign of the larger. Equal magnitudes give +0.
- FSM with two states, ACCUM and HOLD:
  - ACCUM: in_ready=1, out_valid=0.
    - On in_valid&in_ready with cnt==0: acc <= sat_add(bias, in_data); ovf <= overflow of that add.
    - On in_valid&in_ready with cnt>0: acc <= sat_add(acc, in_data); ovf <= ovf | overflow.
    - cnt increments on each accepted term. When the term accepted is number NUM_TERMS (cnt==NUM_TERMS-1), cnt <= 0 and state <= HOLD.
  - HOLD: in_ready=0, out_valid=1.
    - out_data = acc, normalised; if RELU_EN and sign=1, out_data = 0x00000.
    - out_ovf = ovf.
    - On out_ready: state <= ACCUM. out_data, out_valid and out_ovf are held stable until that handshake.
- Latency: out_valid rises on the cycle after the last term is accepted. Minimum window period is NUM_TERMS+1 cycles.
- in_valid while in HOLD is ignored and causes no state change. The producer must hold its data.
- NUM_TERMS=1: result = sat_add(bias, first term).
- Saturation stickiness: once acc has saturated, later opposite-sign terms subtract from 0x1FFFF. The block does not restore the lost precision; this is required behaviour, and out_ovf flags the window.
- Reset: state=ACCUM, cnt=0, acc=0, ovf=0, in_ready=1, out_valid=0, out_data=0, out_ovf=0.
  - Reset mid-window discards the partial sum.
  - Reset in HOLD drops the pending result.
- cnt width: $clog2(NUM_TERMS+1).

Decomposition:
- Shared package:
  - SM_W=18
  - SM_MAG_MAX=17'h1FFFF
  - state enum {ACCUM, HOLD}
  - function for -0 normalisation
- Sub-module fixed_sat_adder: combinational 18-bit sign-magnitude add.
  - Inputs a, b; outputs sum, ovf.
  - Same compare/subtract structure as the existing adder, plus saturation and +0 on cancellation.
  - Instantiated once in the accumulator datapath.

Test Plan:
- Basic window: bias=0x00010, 25 terms of 0x00001, out_ready=1. Required: out_data=0x00029, out_ovf=0, out_valid exactly 1 cycle after the 25th accept, in_ready=0 during that cycle.
- Mixed signs with cancellation, RELU_EN=0: bias=0x20005 (-5), 24 terms of +0x00000, last term 0x00005. Required: out_data=0x00000 (not 0x20000). Then bias=0x00000 with terms netting -3. Required: 0x20003.
- ReLU, RELU_EN=1: bias=0x20064 (-100), 25 terms of 0x00002 (+50 total). Required: out_data=0x00000, out_ovf=0.
- Saturation: bias=0x1FFFF, first term 0x00001, then 24 terms of 0x20001. Required: out_data=0x1FFE7, out_ovf=1. The next window of all-zero terms with bias 0 returns 0x00000 with out_ovf=0.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 driving new data. Required: out_data stable, in_ready=0, no term consumed. After out_ready=1 for one cycle, the next window starts and its first accepted term samples bias.
- Reset mid-window: after 12 terms, pulse rst for 1 cycle. Required: out_valid=0 and in_ready=1 next cycle. A fresh 25-term window then produces a result independent of the aborted terms.
